// File: rtl/soc_uart_programmer_if.sv
// SoC memory bus as seen by one master: request/address/data out, valid/read data back.
interface SoC_MemBus;
  logic        req;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        write_en;
  logic [3:0]  byte_en;
  logic        valid;
  logic [31:0] read_data;

  modport Master (output req, addr, write_data, write_en, byte_en, input valid, read_data);
  modport Slave  (input req, addr, write_data, write_en, byte_en, output valid, read_data);
endinterface

// File: rtl/soc_uart_programmer.sv
// UART byte-protocol programmer: decodes W/R/H/G commands into bus word accesses and core halt control,
// answering with ACK, NAK or read data bytes on the transmit side.
module soc_uart_programmer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          HALT_ON_RESET  = 1'b1
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       core_halt,
  output logic       rx_overrun,
  SoC_MemBus.Master  bus
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t      state_r, state_n;
  logic [1:0]  byte_cnt_r, resp_last_r;
  logic        is_write_r;
  logic [31:0] addr_r, wdata_r, resp_buf_r, timeout_cnt_r;
  logic        req_r, write_en_r, tx_valid_r, core_halt_r, rx_overrun_r;
  logic [3:0]  byte_en_r;
  logic [31:0] addr_shift_s, data_shift_s;
  logic        in_cmd_s, timeout_s, tx_done_s;

  // Next-state decode; bytes are shifted in LSB first, so the new byte enters at the top.
  always_comb begin
    state_n      = state_r;
    addr_shift_s = {rx_data, addr_r[31:8]};
    data_shift_s = {rx_data, wdata_r[31:8]};
    in_cmd_s     = (state_r == ADDR) || (state_r == DATA);
    timeout_s    = in_cmd_s && !rx_valid && (timeout_cnt_r == TIMEOUT_CYCLES - 32'd1);
    tx_done_s    = tx_valid_r && tx_ready && (byte_cnt_r == resp_last_r);
    case (state_r)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_W || rx_data == CMD_R) state_n = ADDR;
          else                                      state_n = RESP;
        end else begin
          state_n = IDLE;
        end
      end
      ADDR: begin
        if (rx_valid) begin
          if (byte_cnt_r == 2'd3) begin
            if (addr_shift_s[1:0] != 2'b00) state_n = RESP;
            else if (is_write_r)            state_n = DATA;
            else                            state_n = BUS;
          end else begin
            state_n = ADDR;
          end
        end else if (timeout_s) begin
          state_n = IDLE;
        end else begin
          state_n = ADDR;
        end
      end
      DATA: begin
        if (rx_valid) begin
          if (byte_cnt_r == 2'd3) state_n = BUS;
          else                    state_n = DATA;
        end else if (timeout_s) begin
          state_n = IDLE;
        end else begin
          state_n = DATA;
        end
      end
      BUS: begin
        if (bus.valid) state_n = RESP;
        else           state_n = BUS;
      end
      RESP: begin
        if (tx_done_s) state_n = IDLE;
        else           state_n = RESP;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, registered outputs and command datapath.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_r       <= IDLE;
      byte_cnt_r    <= 2'd0;
      resp_last_r   <= 2'd0;
      is_write_r    <= 1'b0;
      addr_r        <= 32'd0;
      wdata_r       <= 32'd0;
      resp_buf_r    <= 32'd0;
      timeout_cnt_r <= 32'd0;
      req_r         <= 1'b0;
      write_en_r    <= 1'b0;
      byte_en_r     <= 4'h0;
      tx_valid_r    <= 1'b0;
      rx_overrun_r  <= 1'b0;
      core_halt_r   <= HALT_ON_RESET;
    end else begin
      state_r      <= state_n;
      req_r        <= (state_n == BUS);
      byte_en_r    <= (state_n == BUS) ? 4'hF : 4'h0;
      write_en_r   <= (state_n == BUS) && is_write_r;
      tx_valid_r   <= (state_n == RESP);
      rx_overrun_r <= rx_valid && ((state_r == BUS) || (state_r == RESP));
      if (rx_valid || !in_cmd_s || timeout_s) timeout_cnt_r <= 32'd0;
      else                                    timeout_cnt_r <= timeout_cnt_r + 32'd1;
      case (state_r)
        IDLE: begin
          if (rx_valid) begin
            byte_cnt_r  <= 2'd0;
            resp_last_r <= 2'd0;
            is_write_r  <= (rx_data == CMD_W);
            case (rx_data)
              CMD_H: begin
                core_halt_r <= 1'b1;
                resp_buf_r  <= {24'd0, ACK};
              end
              CMD_G: begin
                core_halt_r <= 1'b0;
                resp_buf_r  <= {24'd0, ACK};
              end
              CMD_W, CMD_R: begin
              end
              default: resp_buf_r <= {24'd0, NAK};
            endcase
          end
        end
        ADDR: begin
          if (rx_valid) begin
            addr_r     <= addr_shift_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (state_n == RESP) resp_buf_r <= {24'd0, NAK};
          end
        end
        DATA: begin
          if (rx_valid) begin
            wdata_r    <= data_shift_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
          end
        end
        BUS: begin
          if (bus.valid) begin
            byte_cnt_r  <= 2'd0;
            resp_last_r <= is_write_r ? 2'd0 : 2'd3;
            resp_buf_r  <= is_write_r ? {24'd0, ACK} : bus.read_data;
          end
        end
        RESP: begin
          if (tx_valid_r && tx_ready) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            resp_buf_r <= {8'd0, resp_buf_r[31:8]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req        = req_r;
  assign bus.addr       = addr_r;
  assign bus.write_data = wdata_r;
  assign bus.write_en   = write_en_r;
  assign bus.byte_en    = byte_en_r;
  assign tx_data        = resp_buf_r[7:0];
  assign tx_valid       = tx_valid_r;
  assign core_halt      = core_halt_r;
  assign rx_overrun     = rx_overrun_r;

endmodule
